// File: rtl/button_event.sv
// Press/release event classifier for a debounced button level: one-cycle press,
// release, short/long press pulses, plus auto-repeat when BUTTON_EVENT_REPEAT_EN is defined.
module button_event #(
   parameter int unsigned          CNT_W        = 8,
   parameter logic [CNT_W-1:0]     LONG_TICKS   = 8'd20,
   parameter logic [CNT_W-1:0]     REPEAT_TICKS = 8'd5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_press,
   output logic long_press,
   output logic repeat_pulse,
   output logic held
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PRESS = 2'b01,
      LONG  = 2'b10
   } state_e;

   // Terminal counts; counters clear on a hit so they never wrap.
   localparam logic [CNT_W-1:0] LONG_LAST = LONG_TICKS - CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             press_d, release_d, short_d, long_d, held_d;

`ifdef BUTTON_EVENT_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = REPEAT_TICKS - CNT_W'(1);

   logic [CNT_W-1:0] rep_q, rep_d;
   logic             repeat_d;
`else
   wire unused_repeat_ticks = ^REPEAT_TICKS;
`endif

   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      state_d   = state_q;
      hold_d    = hold_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      rep_d     = rep_q;
      repeat_d  = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (in) begin
               state_d = PRESS;
               hold_d  = '0;
               press_d = 1'b1;
            end
         end

         PRESS: begin
            // Release is checked first so it wins over the long threshold.
            if (!in) begin
               state_d   = IDLE;
               release_d = 1'b1;
               short_d   = 1'b1;
            end else if (hold_q == LONG_LAST) begin
               state_d = LONG;
               long_d  = 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
               rep_d   = '0;
`endif
            end else begin
               hold_d = hold_q + CNT_W'(1);
            end
         end

         LONG: begin
            if (!in) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end
`ifdef BUTTON_EVENT_REPEAT_EN
            else if (rep_q == REP_LAST) begin
               repeat_d = 1'b1;
               rep_d    = '0;
            end else begin
               rep_d = rep_q + CNT_W'(1);
            end
`endif
         end

         default: begin
            state_d = IDLE;
            hold_d  = '0;
`ifdef BUTTON_EVENT_REPEAT_EN
            rep_d   = '0;
`endif
         end
      endcase

      held_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         hold_q        <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_press   <= 1'b0;
         long_press    <= 1'b0;
         held          <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
         short_press   <= short_d;
         long_press    <= long_d;
         held          <= held_d;
      end
   end

`ifdef BUTTON_EVENT_REPEAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q        <= '0;
         repeat_pulse <= 1'b0;
      end else begin
         rep_q        <= rep_d;
         repeat_pulse <= repeat_d;
      end
   end
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: doc/button_event.md
# button_event

Press/release event classifier that sits directly downstream of the switch debouncer. It consumes the debouncer's clean `out` level and turns it into single-cycle event pulses: press, release, short press and long press, plus optional auto-repeat while the button is held. Its outputs feed counters and menu logic that need one pulse per user action, not a level.

## Interface
Parameters:
- `CNT_W`, 8: hold-counter width.
- `LONG_TICKS`, 8'd20: cycles of continuous hold, counted from the press edge, before `long_press` fires. Legal range is 1 .. 2^CNT_W-1.
- `REPEAT_TICKS`, 8'd5: auto-repeat period in cycles. Legal range is 1 .. 2^CNT_W-1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `in`  in  1: debounced switch level (1 = pressed). Already synchronous to `clk`.
- `press_pulse`  out  1: one-cycle pulse on a press.
- `release_pulse`  out  1: one-cycle pulse on a release.
- `short_press`  out  1: one-cycle pulse on a release that occurs before the long threshold.
- `long_press`  out  1: one-cycle pulse when the hold reaches `LONG_TICKS`.
- `repeat_pulse`  out  1: one-cycle pulse every `REPEAT_TICKS` cycles during a long hold. Tied to 0 when the macro is absent.
- `held`  out  1: high while the FSM is not in IDLE.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Internal reset state:
  - FSM = IDLE
  - `hold_cnt` = 0
  - `rep_cnt` = 0
- FSM states are IDLE, PRESS and LONG. Unused encodings go to IDLE with counters cleared.
- IDLE:
  - `in`=1 → PRESS, `hold_cnt`<=0, and `press_pulse` is pulsed.
  - `in`=0 → stay in IDLE.
- PRESS:
  - `in`=0 → IDLE, and `release_pulse` and `short_press` are pulsed in the same cycle.
  - Else if `hold_cnt`==LONG_TICKS-1 → LONG, `long_press` is pulsed, `rep_cnt`<=0.
  - Else `hold_cnt`<=`hold_cnt`+1.
- LONG:
  - `in`=0 → IDLE, and `release_pulse` is pulsed. `short_press` stays 0.
  - Else, when the macro is present:
    - If `rep_cnt`==REPEAT_TICKS-1, `repeat_pulse` is pulsed and `rep_cnt`<=0.
    - Else `rep_cnt`+1.
- `held` is 1 in PRESS and LONG, and 0 in IDLE.
- Simultaneous events:
  - In PRESS, release on the threshold edge: release wins. `short_press` fires and `long_press` does not.
  - In LONG, release on the repeat edge: release wins. No `repeat_pulse`.
- Pulse counts:
  - Each press yields exactly one `press_pulse` and, eventually, one `release_pulse`.
  - Exactly one of `short_press` / `long_press` fires per press.
- Arithmetic: counters are unsigned `CNT_W` bits. They never wrap, because they are cleared on every comparison hit.
- `in` high when reset releases: the first edge is treated as a press and `press_pulse` fires.
- Reset asserted mid-hold: all outputs clear at once, with no `release_pulse`.

## Timing
Edge k is the first clock edge that samples `in`=1 in IDLE.
- `press_pulse` and `held` are high in the cycle after edge k.
- `long_press` is high in the cycle after edge k+LONG_TICKS, provided `in` stayed 1 through edge k+LONG_TICKS.
- `repeat_pulse` follows edges k+LONG_TICKS+n·REPEAT_TICKS, for n ≥ 1.
- Release latency: if edge r is the first edge sampling `in`=0, then `release_pulse`, plus `short_press` where applicable, is high in the cycle after edge r, and `held` drops in that same cycle.
- Minimum press: one cycle of `in`=1 gives `press_pulse` followed immediately by `release_pulse` + `short_press`.
- Back-to-back: a new press may be accepted on the edge right after the release edge.

## Configuration
- Macro: `BUTTON_EVENT_REPEAT_EN`.
- Defined:
  - The `rep_cnt` register and the auto-repeat logic are compiled in.
  - `repeat_pulse` behaves as described above.
- Undefined:
  - No `rep_cnt` register is built.
  - `repeat_pulse` is held at constant 0.
  - The LONG state only waits for release.
  - Every other behaviour is identical.

## Test plan
Unless noted, LONG_TICKS=20 and REPEAT_TICKS=5.
- Reset with `in`=0 → all outputs 0. Release reset, hold `in`=0 for 10 cycles → no pulses.
- `in`=1 for 5 cycles, then 0 → one `press_pulse`; 5 cycles later one `release_pulse` and one `short_press` together; `held` high for exactly 5 cycles; `long_press` never fires.
- `in`=1 for 32 cycles → `long_press` 20 cycles after `press_pulse`. With the macro, `repeat_pulse` at +25 and +30. On release: `release_pulse` without `short_press`.
- Release on exactly the threshold edge (`in`=1 for 20 cycles, 0 on the 21st edge) → `short_press`, no `long_press`. Same boundary check for a release on the 25th cycle edge: no `repeat_pulse`.
- Assert `rst_n`=0 while in LONG → outputs 0 immediately, no `release_pulse`. Reset released with `in`=1 → `press_pulse` one cycle later.
- Build without `BUTTON_EVENT_REPEAT_EN` and hold for 40 cycles → `repeat_pulse` stays 0; `long_press` and `release_pulse` unchanged.
